// File: rtl/xor_burst_cipher.sv
// xor_burst_cipher: fetches a key once per operation, then XORs a burst of
// data blocks (plain or chained) moving them over valid/ready handshakes.
module xor_burst_cipher #(
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BLOCKS = 16,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw_flag,
    input  logic                  mode,
    input  logic                  key_sel,
    input  logic [CNT_W-1:0]      num_blocks,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] sd_data_in,
    input  logic                  sd_data_valid,
    output logic                  sd_data_ready,
    output logic [DATA_WIDTH-1:0] sd_data_out,
    output logic                  sd_out_valid,
    input  logic                  sd_ready,
    output logic                  reg_file_rw,
    output logic                  reg_file_sel,
    input  logic [DATA_WIDTH-1:0] reg_file_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [CNT_W-1:0]      blocks_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY_REQ  = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_LOAD     = 3'd3,
        S_XOR      = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BLOCKS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t                  state_q, state_d;
    logic                    rw_q, rw_d;
    logic                    mode_q, mode_d;
    logic                    key_sel_q, key_sel_d;
    logic [CNT_W-1:0]        nb_q, nb_d;
    logic [CNT_W-1:0]        blocks_done_q, blocks_done_d;
    logic                    aborted_q, aborted_d;
    logic [DATA_WIDTH-1:0]   key_q, key_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   chain_q, chain_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic [CNT_W-1:0]        nb_clamped;
    logic                    abort_hit;
    logic                    load_fire;
    logic                    write_fire;
    logic                    last_block;

    // Oversized bursts saturate at the largest supported length.
    assign nb_clamped = (num_blocks > MAX_CNT) ? MAX_CNT : num_blocks;

    // Abort only matters while an operation is actually in flight; a
    // transfer coinciding with abort is dropped rather than counted.
    assign abort_hit  = abort && (state_q != S_IDLE) && (state_q != S_DONE);
    assign load_fire  = (state_q == S_LOAD)  && sd_data_valid && !abort;
    assign write_fire = (state_q == S_WRITE) && sd_ready      && !abort;
    assign last_block = ((blocks_done_q + ONE_CNT) == nb_q);

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b0;
            mode_q        <= 1'b0;
            key_sel_q     <= 1'b0;
            nb_q          <= '0;
            blocks_done_q <= '0;
            aborted_q     <= 1'b0;
            key_q         <= '0;
            data_q        <= '0;
            chain_q       <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            mode_q        <= mode_d;
            key_sel_q     <= key_sel_d;
            nb_q          <= nb_d;
            blocks_done_q <= blocks_done_d;
            aborted_q     <= aborted_d;
            key_q         <= key_d;
            data_q        <= data_d;
            chain_q       <= chain_d;
            result_q      <= result_d;
        end
    end

    // Next-state logic; abort overrides every in-flight transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = (nb_clamped == '0) ? S_DONE : S_KEY_REQ;
            S_KEY_REQ:  state_d = S_KEY_WAIT;
            S_KEY_WAIT: state_d = S_LOAD;
            S_LOAD:     if (sd_data_valid) state_d = S_XOR;
            S_XOR:      state_d = S_WRITE;
            S_WRITE:    if (sd_ready) state_d = last_block ? S_DONE : S_LOAD;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_DONE;
        end
    end

    // Datapath updates: latch config at start, fetch key, capture, XOR, chain.
    always_comb begin
        rw_d          = rw_q;
        mode_d        = mode_q;
        key_sel_d     = key_sel_q;
        nb_d          = nb_q;
        blocks_done_d = blocks_done_q;
        aborted_d     = aborted_q;
        key_d         = key_q;
        data_d        = data_q;
        chain_d       = chain_q;
        result_d      = result_q;

        if (state_q == S_IDLE && start) begin
            rw_d          = rw_flag;
            mode_d        = mode;
            key_sel_d     = key_sel;
            nb_d          = nb_clamped;
            blocks_done_d = '0;
            aborted_d     = 1'b0;
            chain_d       = '0;
        end

        if (state_q == S_KEY_WAIT) begin
            key_d = reg_file_data_out;
        end

        if (load_fire) begin
            data_d = sd_data_in;
        end

        if (state_q == S_XOR) begin
            result_d = data_q ^ key_q ^ (mode_q ? chain_q : '0);
        end

        // Encrypt chains on the ciphertext produced, decrypt on the
        // ciphertext consumed, so the two directions invert each other.
        if (write_fire) begin
            blocks_done_d = blocks_done_q + ONE_CNT;
            if (mode_q) begin
                chain_d = rw_q ? result_q : data_q;
            end
        end

        if (abort_hit) begin
            aborted_d = 1'b1;
        end
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        sd_data_ready = (state_q == S_LOAD);
        sd_out_valid  = (state_q == S_WRITE);
        done          = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        reg_file_sel  = ((state_q == S_KEY_REQ) || (state_q == S_KEY_WAIT)) ? key_sel_q : 1'b0;
    end

    assign reg_file_rw = 1'b0;
    assign sd_data_out = result_q;
    assign blocks_done = blocks_done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_xor_burst_cipher.sv
// Directed testbench for xor_burst_cipher.
// Cycle numbering: the cycle in which start is driven is cycle 1.
module tb_xor_burst_cipher;

    localparam int DW = 512;
    localparam int CW = 5;

    localparam logic [DW-1:0] KA   = {16{32'hA5A5A5A5}};
    localparam logic [DW-1:0] KB   = {8{64'hDEADBEEF01234567}};
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rw_flag;
    logic          mode;
    logic          key_sel;
    logic [CW-1:0] num_blocks;
    logic          abort;
    logic [DW-1:0] sd_data_in;
    logic          sd_data_valid;
    logic          sd_data_ready;
    logic [DW-1:0] sd_data_out;
    logic          sd_out_valid;
    logic          sd_ready;
    logic          reg_file_rw;
    logic          reg_file_sel;
    logic [DW-1:0] reg_file_data_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] blocks_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [DW-1:0] din  [0:16];
    logic [DW-1:0] dexp [0:16];

    int done_idx, n_out, sel_first, abort_idx;

    xor_burst_cipher dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .rw_flag           (rw_flag),
        .mode              (mode),
        .key_sel           (key_sel),
        .num_blocks        (num_blocks),
        .abort             (abort),
        .sd_data_in        (sd_data_in),
        .sd_data_valid     (sd_data_valid),
        .sd_data_ready     (sd_data_ready),
        .sd_data_out       (sd_data_out),
        .sd_out_valid      (sd_out_valid),
        .sd_ready          (sd_ready),
        .reg_file_rw       (reg_file_rw),
        .reg_file_sel      (reg_file_sel),
        .reg_file_data_out (reg_file_data_out),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .blocks_done       (blocks_done)
    );

    // Register file model: half 1 holds KA, half 0 holds KB.
    assign reg_file_data_out = reg_file_sel ? KA : KB;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Runs one operation to its done pulse, feeding din[] and checking
    // every presented output against dexp[]. Optional one-shot stalls on
    // the first WRITE (stall_r) and first LOAD (stall_v); optional abort in
    // the first cycle of LOAD number abort_load.
    task automatic run_op(input logic rw, input logic md, input logic ks,
                          input logic [CW-1:0] nb, input int stall_r,
                          input int stall_v, input int abort_load);
        int c0, in_i, loads, idx;
        bit prev_ready;
        @(negedge clk);
        rw_flag = rw; mode = md; key_sel = ks; num_blocks = nb;
        start = 1'b1; sd_data_valid = 1'b0; sd_ready = 1'b0; abort = 1'b0;
        c0 = cyc; in_i = 0; loads = 0; prev_ready = 1'b0;
        n_out = 0; done_idx = -1; sel_first = -1; abort_idx = -1;
        for (int t = 0; t < 400 && done_idx < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            idx = cyc - c0 + 1;
            if (reg_file_rw !== 1'b0) chk_i("reg_file_rw", int'(reg_file_rw), 0);
            if (reg_file_sel && sel_first < 0) sel_first = idx;
            if (done) begin
                done_idx = idx;
            end else begin
                sd_ready = 1'b0;
                if (sd_out_valid) begin
                    chk("sd_data_out", sd_data_out, dexp[n_out]);
                    if (stall_r > 0) stall_r--;
                    else begin
                        sd_ready = 1'b1;
                        n_out++;
                    end
                end
                sd_data_valid = 1'b0;
                if (sd_data_ready) begin
                    if (!prev_ready) loads++;
                    if (abort_load == loads && !prev_ready) begin
                        abort = 1'b1;
                        sd_data_valid = 1'b1;
                        sd_data_in = din[in_i];
                        abort_idx = idx;
                    end else if (stall_v > 0) begin
                        stall_v--;
                    end else begin
                        sd_data_valid = 1'b1;
                        sd_data_in = din[in_i];
                        in_i++;
                    end
                end
                prev_ready = sd_data_ready;
            end
        end
        chk_i("done_seen", int'(done_idx >= 0), 1);
    endtask

    task automatic post_done();
        @(negedge clk);
        chk_i("done_one_cycle", int'(done), 0);
        chk_i("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rw_flag = 1'b0; mode = 1'b0; key_sel = 1'b0;
        num_blocks = '0; abort = 1'b0; sd_data_in = '0; sd_data_valid = 1'b0;
        sd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            din[i] = '0;
            dexp[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sd_data_out", sd_data_out, '0);
        chk_i("reset_ctrl", int'({sd_out_valid, sd_data_ready, reg_file_rw, reg_file_sel}), 0);
        chk_i("reset_status", int'({busy, done, aborted}), 0);
        chk_i("reset_blocks_done", int'(blocks_done), 0);

        // Plain encrypt, N=1, key from half 1
        din[0] = ONES; dexp[0] = {16{32'h5A5A5A5A}};
        run_op(1'b1, 1'b0, 1'b1, 5'd1, 0, 0, 0);
        chk_i("plain1_done_cycle", done_idx, 7);
        chk_i("plain1_sel_first", sel_first, 2);
        chk_i("plain1_n_out", n_out, 1);
        chk_i("plain1_blocks_done", int'(blocks_done), 1);
        chk_i("plain1_aborted", int'(aborted), 0);
        chk("plain1_out_hold", sd_data_out, {16{32'h5A5A5A5A}});
        post_done();

        // Chained encrypt, N=3, key from half 0
        din[0] = 512'd1; din[1] = 512'd2; din[2] = 512'd3;
        dexp[0] = {{7{64'hDEADBEEF01234567}}, 64'hDEADBEEF01234566};
        dexp[1] = 512'd3;
        dexp[2] = KB;
        run_op(1'b1, 1'b1, 1'b0, 5'd3, 0, 0, 0);
        chk_i("cenc_done_cycle", done_idx, 13);
        chk_i("cenc_n_out", n_out, 3);
        chk_i("cenc_blocks_done", int'(blocks_done), 3);
        post_done();

        // Chained decrypt of the ciphertext above
        din[0] = {{7{64'hDEADBEEF01234567}}, 64'hDEADBEEF01234566};
        din[1] = 512'd3; din[2] = KB;
        dexp[0] = 512'd1; dexp[1] = 512'd2; dexp[2] = 512'd3;
        run_op(1'b0, 1'b1, 1'b0, 5'd3, 0, 0, 0);
        chk_i("cdec_n_out", n_out, 3);
        chk_i("cdec_blocks_done", int'(blocks_done), 3);
        post_done();

        // Backpressure: 5 cycles sd_ready low, 4 cycles valid low; plain
        // mode with rw_flag=0 must give the same result as encrypt.
        din[0] = '0; din[1] = {16{32'hFFFF0000}};
        dexp[0] = KA; dexp[1] = {16{32'h5A5AA5A5}};
        run_op(1'b0, 1'b0, 1'b1, 5'd2, 5, 4, 0);
        chk_i("bp_done_cycle", done_idx, 19);
        chk_i("bp_n_out", n_out, 2);
        chk_i("bp_blocks_done", int'(blocks_done), 2);
        post_done();

        // Zero-length burst
        run_op(1'b1, 1'b0, 1'b1, 5'd0, 0, 0, 0);
        chk_i("n0_done_cycle", done_idx, 2);
        chk_i("n0_no_sel", sel_first, -1);
        chk_i("n0_blocks_done", int'(blocks_done), 0);
        post_done();

        // Oversized burst clamps to 16
        for (int i = 0; i < 16; i++) begin
            din[i] = 512'(i);
            dexp[i] = KA ^ 512'(i);
        end
        run_op(1'b1, 1'b0, 1'b1, 5'd31, 0, 0, 0);
        chk_i("n31_done_cycle", done_idx, 52);
        chk_i("n31_n_out", n_out, 16);
        chk_i("n31_blocks_done", int'(blocks_done), 16);
        post_done();

        // Abort in the second LOAD of a 4-block chained burst
        din[0] = 512'd1; din[1] = 512'd2; din[2] = 512'd3; din[3] = 512'd4;
        dexp[0] = {{7{64'hDEADBEEF01234567}}, 64'hDEADBEEF01234566};
        run_op(1'b1, 1'b1, 1'b0, 5'd4, 0, 0, 2);
        chk_i("abort_next_cycle", done_idx - abort_idx, 1);
        chk_i("abort_flag", int'(aborted), 1);
        chk_i("abort_blocks_done", int'(blocks_done), 1);
        chk_i("abort_n_out", n_out, 1);
        post_done();
        chk_i("abort_flag_held", int'(aborted), 1);

        // Next start clears aborted
        din[0] = ONES; dexp[0] = ~KB;
        run_op(1'b1, 1'b0, 1'b0, 5'd1, 0, 0, 0);
        chk_i("post_abort_aborted", int'(aborted), 0);
        chk_i("post_abort_blocks_done", int'(blocks_done), 1);
        post_done();

        // Reset asserted while in WRITE
        @(negedge clk);
        rw_flag = 1'b1; mode = 1'b0; key_sel = 1'b1; num_blocks = 5'd1;
        start = 1'b1; sd_data_valid = 1'b1; sd_data_in = ONES; sd_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20 && !sd_out_valid; t++) @(negedge clk);
        chk_i("rst_reached_write", int'(sd_out_valid), 1);
        rst = 1'b1;
        sd_data_valid = 1'b0;
        @(negedge clk);
        chk("rst_write_data_out", sd_data_out, '0);
        chk_i("rst_write_ctrl", int'({sd_out_valid, sd_data_ready, reg_file_sel, busy, done}), 0);
        chk_i("rst_write_blocks_done", int'(blocks_done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_i("rst_write_no_done", int'(done), 0);

        // Fresh operation after reset
        din[0] = ONES; dexp[0] = {16{32'h5A5A5A5A}};
        run_op(1'b1, 1'b0, 1'b1, 5'd1, 0, 0, 0);
        chk_i("after_rst_done_cycle", done_idx, 7);
        chk_i("after_rst_blocks_done", int'(blocks_done), 1);
        post_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_burst_cipher.md
# xor_burst_cipher

Parametrised multi-block XOR cipher engine that sits between the SD controller and the key register file. It fetches a key once per operation and processes a burst of `num_blocks` data blocks using valid/ready handshakes on both SD sides. Two modes are supported: plain per-block XOR, and chained XOR (CBC-style), where each block also mixes in the previous ciphertext. It also provides abort, busy, progress count and a one-cycle done pulse.

## Interface
- `DATA_WIDTH`, 512: data block and key width. The key register file half is this width.
- `MAX_BLOCKS`, 16: largest supported burst length.
- `CNT_W`, $clog2(MAX_BLOCKS+1): width of the block-count signals.
- Reset is `rst`, synchronous, active-high. The clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin an operation; sampled only in IDLE
- `rw_flag`  in  1  1 = encrypt, 0 = decrypt; latched at start
- `mode`  in  1  0 = plain XOR, 1 = chained XOR; latched at start
- `key_sel`  in  1  register-file half holding the key; latched at start
- `num_blocks`  in  CNT_W  burst length; latched at start; values above MAX_BLOCKS are clamped to MAX_BLOCKS
- `abort`  in  1  terminate the current operation
- `sd_data_in`  in  DATA_WIDTH  input block
- `sd_data_valid`  in  1  `sd_data_in` is valid
- `sd_data_ready`  out  1  engine accepts an input block
- `sd_data_out`  out  DATA_WIDTH  result block
- `sd_out_valid`  out  1  `sd_data_out` is valid
- `sd_ready`  in  1  SD side accepts the result
- `reg_file_rw`  out  1  register-file direction; this block only ever drives 0 (read)
- `reg_file_sel`  out  1  register-file half select
- `reg_file_data_out`  in  DATA_WIDTH  key from the register file
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse at the end of an operation
- `aborted`  out  1  set when an operation ends by abort; cleared at the next accepted start
- `blocks_done`  out  CNT_W  number of blocks written in the current or last operation

## Operation
- States and transitions:
  - IDLE: on `start`, go to KEY_REQ. The latched `num_blocks` is clamped; if it is 0, go straight to DONE instead.
  - KEY_REQ: go to KEY_WAIT.
  - KEY_WAIT: capture `reg_file_data_out` into the key register, then go to LOAD.
  - LOAD: when `sd_data_valid` is high, capture the input block and go to XOR.
  - XOR: compute the result, then go to WRITE.
  - WRITE: when `sd_ready` is high, increment `blocks_done`. If `blocks_done+1 == num_blocks`, go to DONE; otherwise go to LOAD.
  - DONE: go to IDLE.
- `reg_file_sel` equals the latched `key_sel` in KEY_REQ and KEY_WAIT, and 0 in all other states. `reg_file_rw` is always 0.
- Result in plain mode: `r = d ^ key`.
- Result in chained mode: `r = d ^ key ^ chain`. The chain register is cleared to 0 at start.
  - Encrypt: after each block is written, the chain register takes the result `r`.
  - Decrypt: the chain register takes the captured input block `d`.
- `rw_flag` has no effect in plain mode.
- The key is fetched once per operation and is not re-read between blocks.
- Abort:
  - `abort` high in any state other than IDLE or DONE forces the next state to DONE and sets `aborted`.
  - No further handshakes are accepted or issued after the abort.
  - A block being transferred in the same cycle is not counted.
  - `abort` is ignored in IDLE, so `start` together with `abort` in IDLE starts normally.
- `start` is ignored while `busy` is high.
- Reset, including mid-operation: the state returns to IDLE, every register is cleared, and no `done` pulse is produced.

## Timing
- Reset values: `sd_data_out`=0, `sd_out_valid`=0, `sd_data_ready`=0, `reg_file_rw`=0, `reg_file_sel`=0, `busy`=0, `done`=0, `aborted`=0, `blocks_done`=0.
- `sd_data_ready` = (state==LOAD). `sd_out_valid` = (state==WRITE). `done` = (state==DONE).
- `sd_data_out` is driven from the result register. It is held stable throughout WRITE, including while `sd_ready` is low, and holds its last value outside WRITE.
- A transfer occurs on any clock edge where valid and ready are both high.
- Start-to-first-ready latency: `start` sampled at edge 0 gives KEY_REQ at cycle 1, KEY_WAIT at cycle 2 and `sd_data_ready` high at cycle 3.
- Per-block minimum is 3 cycles (LOAD, XOR, WRITE) with no backpressure.
- Minimum total is 3 + 3N + 1 cycles from start to `done`.
- `blocks_done` updates on the clock edge that completes the WRITE handshake.

## Test plan
- Plain encrypt, N=1: key={16{32'hA5A5A5A5}}, data all ones → `sd_data_out`={16{32'h5A5A5A5A}}, `done` pulses at cycle 7, `blocks_done`=1.
- Chained encrypt, N=3: plaintexts 1, 2, 3 (zero-extended), key K → outputs 1^K, 3, K. Chained decrypt of 1^K, 3, K with the same K → outputs 1, 2, 3.
- Backpressure: hold `sd_ready` low for 5 cycles in WRITE and drop `sd_data_valid` for 4 cycles in LOAD → output stays stable, no data is lost, and total latency grows by exactly 9 cycles.
- `num_blocks`=0 → `done` 2 cycles after start, no `reg_file_sel` activity, `blocks_done`=0. `num_blocks`=31 → exactly 16 blocks are processed.
- Abort during the 2nd LOAD of N=4 → DONE next cycle, `aborted`=1, `blocks_done`=1. The next start clears `aborted`.
- `rst` asserted in WRITE → next cycle all outputs are at reset values and no `done` pulse occurs. A new operation then runs correctly.
